multicycle_controller: RTL and testbench

- Sequencing controller that converts the single-cycle datapath into a multicycle machine.
- Takes the 12-bit instruction field bundle {Cond[3:0], Op[1:0], Funct[5:0]} plus Rd from the decode stage, and raw ALU flags from the ALU.
- Runs a per-instruction FSM, holds the architectural NZCV register, evaluates ARM condition codes, and drives every datapath enable and mux select.
- Stalls on a memory-ready handshake.

---
 rtl/ctrl_pkg.sv | 92 +++++++++
 rtl/cond_unit.sv | 35 +++
 rtl/multicycle_controller.sv | 164 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU operations,
// instruction fields and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_UNKNOWN
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UNK = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_RF   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       no_write;
    logic       valid;
    logic       is_cmp;
    logic       arith;
  } dp_dec_t;

  // Unsupported cmd values fall back to a harmless ADD with no register or flag update.
  function automatic dp_dec_t decode_cmd(input logic [3:0] cmd);
    dp_dec_t d;
    d = '{alu_ctl: ALU_ADD, no_write: 1'b1, valid: 1'b0, is_cmp: 1'b0, arith: 1'b0};
    case (cmd)
      CMD_ADD: d = '{alu_ctl: ALU_ADD, no_write: 1'b0, valid: 1'b1, is_cmp: 1'b0, arith: 1'b1};
      CMD_SUB: d = '{alu_ctl: ALU_SUB, no_write: 1'b0, valid: 1'b1, is_cmp: 1'b0, arith: 1'b1};
      CMD_AND: d = '{alu_ctl: ALU_AND, no_write: 1'b0, valid: 1'b1, is_cmp: 1'b0, arith: 1'b0};
      CMD_ORR: d = '{alu_ctl: ALU_ORR, no_write: 1'b0, valid: 1'b1, is_cmp: 1'b0, arith: 1'b0};
      CMD_EOR: d = '{alu_ctl: ALU_EOR, no_write: 1'b0, valid: 1'b1, is_cmp: 1'b0, arith: 1'b0};
      CMD_MOV: d = '{alu_ctl: ALU_MOV, no_write: 1'b0, valid: 1'b1, is_cmp: 1'b0, arith: 1'b0};
      CMD_CMP: d = '{alu_ctl: ALU_SUB, no_write: 1'b1, valid: 1'b1, is_cmp: 1'b1, arith: 1'b1};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// ARM condition-code evaluation against an NZCV flag vector.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer: per-instruction FSM, NZCV register and datapath control.
// States: FETCH/DECODE common, MEMADR->MEMRD->MEMWB or MEMWR, EXECR|EXECI->ALUWB, BRANCH, UNKNOWN.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter bit PC_WRITE_ON_RD15 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] ToControler,
  input  logic [3:0]  Rd,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  Flags
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       s_bit;
  dp_dec_t    dp_dec;

  state_t     state, state_next;
  logic       cond_q;
  logic       cond_ex;
  logic [3:0] flags_q;
  logic       in_exec;
  logic       flag_upd;
  logic       nz_en, cv_en;
  logic       reg_wr;

  assign cond   = ToControler[11:8];
  assign op     = ToControler[7:6];
  assign funct  = ToControler[5:0];
  assign s_bit  = funct[0];
  assign dp_dec = decode_cmd(funct[4:1]);
  assign Flags  = flags_q;

  cond_unit u_cond (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // CMP always updates flags; unsupported commands never do.
  assign in_exec  = (state == S_EXECR) || (state == S_EXECI);
  assign flag_upd = in_exec & cond_q & dp_dec.valid & (s_bit | dp_dec.is_cmp);
  assign nz_en    = flag_upd;
  assign cv_en    = flag_upd & dp_dec.arith;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      cond_q  <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      state <= state_next;
      if (state == S_DECODE) cond_q <= cond_ex;
      if (nz_en) flags_q[3:2] <= ALUFlags[3:2];
      if (cv_en) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RF;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_8;
    reg_wr     = 1'b0;

    case (state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        case (op)
          OP_DP:   state_next = funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_next = S_MEMADR;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_12;
        state_next = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_RDATA;
        RegWrite   = cond_q;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_q;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        ALUControl = dp_dec.alu_ctl;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = dp_dec.alu_ctl;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr     = cond_q & ~dp_dec.no_write;
        RegWrite   = reg_wr;
        PCWrite    = reg_wr & (Rd == 4'd15) & PC_WRITE_ON_RD15;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_24;
        ResultSrc  = RES_ALURES;
        PCWrite    = cond_q;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // Suppress every write enable while reset is held so an aborted access leaves no trace.
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign RegSrc = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table plus stall and latency sequences.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] ToControler;
  logic [3:0]  Rd;
  logic [3:0]  ALUFlags;
  logic        mem_ready;

  logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0]  ALUControl, Flags;

  logic        np_PCWrite, np_IRWrite, np_AdrSrc, np_MemWrite, np_RegWrite, np_ALUSrcA;
  logic [1:0]  np_ResultSrc, np_ALUSrcB, np_ImmSrc, np_RegSrc;
  logic [3:0]  np_ALUControl, np_Flags;

  multicycle_controller #(.PC_WRITE_ON_RD15(1'b1)) dut (
    .clk(clk), .reset(reset), .ToControler(ToControler), .Rd(Rd), .ALUFlags(ALUFlags),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags)
  );

  multicycle_controller #(.PC_WRITE_ON_RD15(1'b0)) dut_np (
    .clk(clk), .reset(reset), .ToControler(ToControler), .Rd(Rd), .ALUFlags(ALUFlags),
    .mem_ready(mem_ready), .PCWrite(np_PCWrite), .IRWrite(np_IRWrite), .AdrSrc(np_AdrSrc),
    .MemWrite(np_MemWrite), .RegWrite(np_RegWrite), .ResultSrc(np_ResultSrc),
    .ALUSrcA(np_ALUSrcA), .ALUSrcB(np_ALUSrcB), .ALUControl(np_ALUControl),
    .ImmSrc(np_ImmSrc), .RegSrc(np_RegSrc), .Flags(np_Flags)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] I_ADDI  = 12'b1110_00_101000;
  localparam logic [11:0] I_CMP   = 12'b1110_00_010101;
  localparam logic [11:0] I_BEQ   = 12'b0000_10_000000;
  localparam logic [11:0] I_BNE   = 12'b0001_10_000000;
  localparam logic [11:0] I_LDR   = 12'b1110_01_011001;
  localparam logic [11:0] I_SUBSI = 12'b1110_00_100101;
  localparam logic [11:0] I_ANDS  = 12'b1110_00_000001;
  localparam logic [11:0] I_STREQ = 12'b0000_01_011000;
  localparam logic [11:0] I_MOV   = 12'b1110_00_011010;
  localparam logic [11:0] I_STR   = 12'b1110_01_011000;
  localparam logic [11:0] I_UNK   = 12'b1110_11_000000;

  typedef struct {
    logic rst; logic [11:0] instr; logic [3:0] rd; logic [3:0] aflags; logic mr;
    state_t st;
    logic pcw, irw, adr, memw, regw;
    logic [1:0] res; logic srca; logic [1:0] srcb; logic [3:0] aluc; logic [1:0] imm;
    logic [1:0] regsrc; logic [3:0] flags;
    logic rd15;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t row(
    input logic rst, input logic [11:0] instr, input logic [3:0] rd, input logic [3:0] aflags,
    input logic mr, input state_t st,
    input logic pcw, input logic irw, input logic adr, input logic memw, input logic regw,
    input logic [1:0] res, input logic srca, input logic [1:0] srcb, input logic [3:0] aluc,
    input logic [1:0] imm, input logic [1:0] regsrc, input logic [3:0] flags, input logic rd15);
    vec_t v;
    v.rst = rst; v.instr = instr; v.rd = rd; v.aflags = aflags; v.mr = mr; v.st = st;
    v.pcw = pcw; v.irw = irw; v.adr = adr; v.memw = memw; v.regw = regw;
    v.res = res; v.srca = srca; v.srcb = srcb; v.aluc = aluc; v.imm = imm;
    v.regsrc = regsrc; v.flags = flags; v.rd15 = rd15;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [21:0] dut_bundle();
    return {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ALUControl, ImmSrc, RegSrc, Flags};
  endfunction

  // Issue one instruction from FETCH with memory always ready; count cycles until the next fetch.
  task automatic run_instr(input string name, input logic [11:0] instr, input int exp_cycles);
    int n;
    ToControler = instr; Rd = 4'd1; ALUFlags = 4'b0000; mem_ready = 1'b1;
    #1;
    check({name, " fetch"}, 32'(IRWrite), 32'd1);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (IRWrite) break;
      n++;
    end
    check({name, " cycles"}, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [21:0] exp_b;

    // ADD R1,R2,#5
    vecs.push_back(row(0,I_ADDI,1,4'h0,1,S_FETCH,  1,1,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h0,0));
    vecs.push_back(row(0,I_ADDI,1,4'h0,1,S_DECODE, 0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h0,0));
    vecs.push_back(row(0,I_ADDI,1,4'h0,1,S_EXECI,  0,0,0,0,0, 2'b00,0,2'b01,4'h0,2'b00,2'b00,4'h0,0));
    vecs.push_back(row(0,I_ADDI,1,4'h0,1,S_ALUWB,  0,0,0,0,1, 2'b00,0,2'b00,4'h0,2'b00,2'b00,4'h0,0));
    // CMP with Z from ALU
    vecs.push_back(row(0,I_CMP,0,4'h4,1,S_FETCH,   1,1,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h0,0));
    vecs.push_back(row(0,I_CMP,0,4'h4,1,S_DECODE,  0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h0,0));
    vecs.push_back(row(0,I_CMP,0,4'h4,1,S_EXECR,   0,0,0,0,0, 2'b00,0,2'b00,4'h1,2'b00,2'b00,4'h0,0));
    vecs.push_back(row(0,I_CMP,0,4'h0,1,S_ALUWB,   0,0,0,0,0, 2'b00,0,2'b00,4'h0,2'b00,2'b00,4'h4,0));
    // BEQ taken, BNE not taken
    vecs.push_back(row(0,I_BEQ,0,4'h0,1,S_FETCH,   1,1,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b01,4'h4,0));
    vecs.push_back(row(0,I_BEQ,0,4'h0,1,S_DECODE,  0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b01,4'h4,0));
    vecs.push_back(row(0,I_BEQ,0,4'h0,1,S_BRANCH,  1,0,0,0,0, 2'b10,0,2'b01,4'h0,2'b10,2'b01,4'h4,0));
    vecs.push_back(row(0,I_BNE,0,4'h0,1,S_FETCH,   1,1,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b01,4'h4,0));
    vecs.push_back(row(0,I_BNE,0,4'h0,1,S_DECODE,  0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b01,4'h4,0));
    vecs.push_back(row(0,I_BNE,0,4'h0,1,S_BRANCH,  0,0,0,0,0, 2'b10,0,2'b01,4'h0,2'b10,2'b01,4'h4,0));
    // LDR with three wait cycles in MEMRD
    vecs.push_back(row(0,I_LDR,2,4'h0,1,S_FETCH,   1,1,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h4,0));
    vecs.push_back(row(0,I_LDR,2,4'h0,1,S_DECODE,  0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h4,0));
    vecs.push_back(row(0,I_LDR,2,4'h0,1,S_MEMADR,  0,0,0,0,0, 2'b00,0,2'b01,4'h0,2'b01,2'b00,4'h4,0));
    vecs.push_back(row(0,I_LDR,2,4'h0,0,S_MEMRD,   0,0,1,0,0, 2'b00,0,2'b00,4'h0,2'b00,2'b00,4'h4,0));
    vecs.push_back(row(0,I_LDR,2,4'h0,0,S_MEMRD,   0,0,1,0,0, 2'b00,0,2'b00,4'h0,2'b00,2'b00,4'h4,0));
    vecs.push_back(row(0,I_LDR,2,4'h0,0,S_MEMRD,   0,0,1,0,0, 2'b00,0,2'b00,4'h0,2'b00,2'b00,4'h4,0));
    vecs.push_back(row(0,I_LDR,2,4'h0,1,S_MEMRD,   0,0,1,0,0, 2'b00,0,2'b00,4'h0,2'b00,2'b00,4'h4,0));
    vecs.push_back(row(0,I_LDR,2,4'h0,1,S_MEMWB,   0,0,0,0,1, 2'b01,0,2'b00,4'h0,2'b00,2'b00,4'h4,0));
    // SUBS R4,#imm with C only: all four flags written
    vecs.push_back(row(0,I_SUBSI,4,4'h2,1,S_FETCH, 1,1,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h4,0));
    vecs.push_back(row(0,I_SUBSI,4,4'h2,1,S_DECODE,0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h4,0));
    vecs.push_back(row(0,I_SUBSI,4,4'h2,1,S_EXECI, 0,0,0,0,0, 2'b00,0,2'b01,4'h1,2'b00,2'b00,4'h4,0));
    vecs.push_back(row(0,I_SUBSI,4,4'h0,1,S_ALUWB, 0,0,0,0,1, 2'b00,0,2'b00,4'h0,2'b00,2'b00,4'h2,0));
    // ANDS: only N,Z follow the ALU, C,V hold
    vecs.push_back(row(0,I_ANDS,5,4'hB,1,S_FETCH,  1,1,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h2,0));
    vecs.push_back(row(0,I_ANDS,5,4'hB,1,S_DECODE, 0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h2,0));
    vecs.push_back(row(0,I_ANDS,5,4'hB,1,S_EXECR,  0,0,0,0,0, 2'b00,0,2'b00,4'h2,2'b00,2'b00,4'h2,0));
    vecs.push_back(row(0,I_ANDS,5,4'h0,1,S_ALUWB,  0,0,0,0,1, 2'b00,0,2'b00,4'h0,2'b00,2'b00,4'hA,0));
    // STREQ with Z clear: no memory write
    vecs.push_back(row(0,I_STREQ,6,4'h0,1,S_FETCH, 1,1,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b10,4'hA,0));
    vecs.push_back(row(0,I_STREQ,6,4'h0,1,S_DECODE,0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b10,4'hA,0));
    vecs.push_back(row(0,I_STREQ,6,4'h0,1,S_MEMADR,0,0,0,0,0, 2'b00,0,2'b01,4'h0,2'b01,2'b10,4'hA,0));
    vecs.push_back(row(0,I_STREQ,6,4'h0,1,S_MEMWR, 0,0,1,0,0, 2'b00,0,2'b00,4'h0,2'b00,2'b10,4'hA,0));
    // MOV PC,R3
    vecs.push_back(row(0,I_MOV,15,4'h0,1,S_FETCH,  1,1,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'hA,0));
    vecs.push_back(row(0,I_MOV,15,4'h0,1,S_DECODE, 0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'hA,0));
    vecs.push_back(row(0,I_MOV,15,4'h0,1,S_EXECR,  0,0,0,0,0, 2'b00,0,2'b00,4'h5,2'b00,2'b00,4'hA,0));
    vecs.push_back(row(0,I_MOV,15,4'h0,1,S_ALUWB,  1,0,0,0,1, 2'b00,0,2'b00,4'h0,2'b00,2'b00,4'hA,1));
    // STR stalled in MEMWR, then reset aborts it
    vecs.push_back(row(0,I_STR,7,4'h0,1,S_FETCH,   1,1,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b10,4'hA,0));
    vecs.push_back(row(0,I_STR,7,4'h0,1,S_DECODE,  0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b10,4'hA,0));
    vecs.push_back(row(0,I_STR,7,4'h0,1,S_MEMADR,  0,0,0,0,0, 2'b00,0,2'b01,4'h0,2'b01,2'b10,4'hA,0));
    vecs.push_back(row(0,I_STR,7,4'h0,0,S_MEMWR,   0,0,1,1,0, 2'b00,0,2'b00,4'h0,2'b00,2'b10,4'hA,0));
    vecs.push_back(row(1,I_STR,7,4'h0,0,S_MEMWR,   0,0,1,0,0, 2'b00,0,2'b00,4'h0,2'b00,2'b10,4'hA,0));
    vecs.push_back(row(0,I_STR,7,4'h0,0,S_FETCH,   0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b10,4'h0,0));
    // Undefined opcode
    vecs.push_back(row(0,I_UNK,0,4'h0,1,S_FETCH,   1,1,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h0,0));
    vecs.push_back(row(0,I_UNK,0,4'h0,1,S_DECODE,  0,0,0,0,0, 2'b10,1,2'b10,4'h0,2'b00,2'b00,4'h0,0));
    vecs.push_back(row(0,I_UNK,0,4'h0,1,S_UNKNOWN, 0,0,0,0,0, 2'b00,0,2'b00,4'h0,2'b00,2'b00,4'h0,0));

    reset = 1'b1; ToControler = 12'h000; Rd = 4'd0; ALUFlags = 4'h0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      reset = v.rst; ToControler = v.instr; Rd = v.rd; ALUFlags = v.aflags; mem_ready = v.mr;
      #1;
      exp_b = {v.pcw, v.irw, v.adr, v.memw, v.regw, v.res, v.srca, v.srcb, v.aluc, v.imm,
               v.regsrc, v.flags};
      check($sformatf("row%0d state", i), 32'(dut.state), 32'(v.st));
      check($sformatf("row%0d controls", i), 32'(dut_bundle()), 32'(exp_b));
      check($sformatf("row%0d pcwrite_no_rd15", i), 32'(np_PCWrite), 32'(v.pcw & ~v.rd15));
    end

    // FETCH must hold with no IR/PC write while memory is not ready
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ready = 1'b0; ToControler = I_ADDI;
      #1;
      check($sformatf("fetch stall%0d irwrite", k), 32'(IRWrite), 32'd0);
      check($sformatf("fetch stall%0d pcwrite", k), 32'(PCWrite), 32'd0);
    end

    // Cycles per instruction with memory always ready (states visited before the next FETCH)
    run_instr("latency dp", I_ADDI, 4);
    run_instr("latency ldr", I_LDR, 5);
    run_instr("latency str", I_STR, 4);
    run_instr("latency unknown", I_UNK, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
